// File: rtl/swipe_sequencer_pkg.sv
// Shared definitions for the swipe sequencer and the other blinky blocks:
// the mode encoding and a small helper.
package swipe_sequencer_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    function automatic logic mode_is_on(input mode_t m);
        return m != MODE_OFF;
    endfunction

endpackage

// File: rtl/swipe_sequencer_if.sv
// Board-facing bundle of the swipe sequencer: mode request in, LED drive,
// frame pulse, activity flag and sequencer debug state out.
interface swipe_sequencer_if
    import swipe_sequencer_pkg::*;
#(
    parameter int N_LEDS = 6,
    parameter int STEP_W = 5
);

    // No valid/ready here: mode is a level, sampled only on the tick that
    // opens a frame; every output is a register updated one clk after a tick.
    mode_t              mode;
    logic [N_LEDS-1:0]  led;
    logic               frame_strt;
    logic               active;
    logic [STEP_W-1:0]  dbg_step;
    mode_t              dbg_mode;

    modport master (
        output mode,
        input  led, frame_strt, active, dbg_step, dbg_mode
    );

    modport slave (
        input  mode,
        output led, frame_strt, active, dbg_step, dbg_mode
    );

endinterface

// File: rtl/swipe_sequencer_tick_divider.sv
// Tick divider: free-running counter 0..TICK_DIV-1, tick is high for the one
// cycle in which the counter sits at its last value and is about to wrap.
module swipe_sequencer_tick_divider #(
    parameter int TICK_DIV = 1048576
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/swipe_sequencer.sv
// Sequential turn-signal driver: per frame, lights the strip one LED per step in
// the latched direction, holds it lit, and clears it at the next frame boundary.
module swipe_sequencer
    import swipe_sequencer_pkg::*;
#(
    parameter int N_LEDS      = 6,
    parameter int TICK_DIV    = 1048576,
    parameter int FRAME_STEPS = 32,
    parameter int START_STEP  = 9,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             reset,
    swipe_sequencer_if.slave bus
);

    localparam int SW = $clog2(FRAME_STEPS);
    localparam logic [SW-1:0] LAST_STEP = SW'(FRAME_STEPS - 1);
    localparam int C_LO = (N_LEDS - 1) / 2;
    localparam int C_HI = N_LEDS / 2;

    logic              tick;
    logic [SW-1:0]     step;
    mode_t             cur_mode;
    logic [N_LEDS-1:0] lit;
    logic [N_LEDS-1:0] sweep_mask;
    logic [N_LEDS-1:0] lit_next;
    logic [N_LEDS-1:0] led_q;
    logic              frame_strt_q;
    logic              active_q;
    int                k;

    swipe_sequencer_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    function automatic logic [N_LEDS-1:0] to_pins(input logic [N_LEDS-1:0] m);
        return (ACTIVE_LOW != 0) ? ~m : m;
    endfunction

    // LEDs newly lit at the current step; k is the sweep position, and positions
    // outside the strip light nothing (this also trims the hazard fan-out).
    always_comb begin
        sweep_mask = '0;
        k = int'(step) - START_STEP;
        for (int i = 0; i < N_LEDS; i++) begin
            if (k >= 0 && k < N_LEDS) begin
                case (cur_mode)
                    MODE_LEFT:   sweep_mask[i] = (k == i);
                    MODE_RIGHT:  sweep_mask[i] = (k == N_LEDS - 1 - i);
                    MODE_HAZARD: sweep_mask[i] = (k == C_LO - i) || (k == i - C_HI);
                    default:     sweep_mask[i] = 1'b0;
                endcase
            end
        end
    end

    assign lit_next = lit | sweep_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            step         <= '0;
            cur_mode     <= MODE_OFF;
            lit          <= '0;
            led_q        <= to_pins('0);
            frame_strt_q <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            frame_strt_q <= 1'b0;
            if (tick) begin
                if (step == '0) begin
                    // Frame boundary: the only place the requested mode is taken.
                    cur_mode     <= bus.mode;
                    lit          <= '0;
                    led_q        <= to_pins('0);
                    frame_strt_q <= 1'b1;
                    active_q     <= mode_is_on(bus.mode);
                    if (mode_is_on(bus.mode)) begin
                        step <= SW'(1);
                    end
                end else begin
                    lit   <= lit_next;
                    led_q <= to_pins(lit_next);
                    step  <= (step == LAST_STEP) ? '0 : step + SW'(1);
                end
            end
        end
    end

    assign bus.led        = led_q;
    assign bus.frame_strt = frame_strt_q;
    assign bus.active     = active_q;
    assign bus.dbg_step   = step;
    assign bus.dbg_mode   = cur_mode;

endmodule

// File: tb/tb_swipe_sequencer.sv
// Bench for swipe_sequencer: directed scenarios plus random mode/reset traffic,
// checked every cycle against a frame-level model of the LED sweep.
module tb_swipe_sequencer
    import swipe_sequencer_pkg::*;
;

    localparam int N    = 6;
    localparam int TDIV = 4;
    localparam int FS   = 16;
    localparam int ST   = 4;
    localparam int SW   = 4;

    logic clk;
    logic reset;
    logic cmp_en;
    int   checks;
    int   errors;

    swipe_sequencer_if #(.N_LEDS(N), .STEP_W(SW)) bus_l ();
    swipe_sequencer_if #(.N_LEDS(N), .STEP_W(SW)) bus_h ();

    assign bus_h.mode = bus_l.mode;

    swipe_sequencer #(
        .N_LEDS(N), .TICK_DIV(TDIV), .FRAME_STEPS(FS), .START_STEP(ST), .ACTIVE_LOW(1)
    ) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l)
    );

    swipe_sequencer #(
        .N_LEDS(N), .TICK_DIV(TDIV), .FRAME_STEPS(FS), .START_STEP(ST), .ACTIVE_LOW(0)
    ) dut_h (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_h)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int    m_cyc;
    int    m_next;
    int    m_shown;
    mode_t m_mode;
    logic  m_fs;
    logic  m_act;

    // Set of lit LEDs once step s of a frame in mode m has been processed.
    function automatic logic [N-1:0] exp_lit(input mode_t m, input int s);
        logic [N-1:0] r;
        int n;
        int c;
        int c2;
        r  = '0;
        c  = (N - 1) / 2;
        c2 = N / 2;
        n  = s - ST + 1;
        if (n < 0) n = 0;
        if (n > N) n = N;
        for (int i = 0; i < N; i++) begin
            case (m)
                MODE_LEFT:   r[i] = (i < n);
                MODE_RIGHT:  r[i] = (i >= N - n);
                MODE_HAZARD: r[i] = (i <= c && c - i < n) || (i >= c2 && i - c2 < n);
                default:     r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_led_lo();
        logic [N-1:0] v;
        v = exp_lit(m_mode, m_shown);
        return ~v;
    endfunction

    function automatic logic [N-1:0] exp_led_hi();
        return exp_lit(m_mode, m_shown);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cyc   = 0;
            m_next  = 0;
            m_shown = 0;
            m_mode  = MODE_OFF;
            m_fs    = 1'b0;
            m_act   = 1'b0;
        end else begin
            m_fs = 1'b0;
            if (m_cyc % TDIV == TDIV - 1) begin
                if (m_next == 0) begin
                    m_mode  = bus_l.mode;
                    m_shown = 0;
                    m_fs    = 1'b1;
                    m_act   = (bus_l.mode != MODE_OFF);
                    m_next  = (bus_l.mode == MODE_OFF) ? 0 : 1;
                end else begin
                    m_shown = m_next;
                    m_next  = (m_next + 1) % FS;
                end
            end
            m_cyc = m_cyc + 1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("led_lo", {26'd0, bus_l.led}, {26'd0, exp_led_lo()});
            chk("led_hi", {26'd0, bus_h.led}, {26'd0, exp_led_hi()});
            chk("frame_strt", {31'd0, bus_l.frame_strt}, {31'd0, m_fs});
            chk("frame_strt_hi", {31'd0, bus_h.frame_strt}, {31'd0, m_fs});
            chk("active", {31'd0, bus_l.active}, {31'd0, m_act});
            chk("dbg_step", {28'd0, bus_l.dbg_step}, m_next);
            chk("dbg_mode", {30'd0, bus_l.dbg_mode}, {30'd0, m_mode});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pin_led(input string nm, input logic [N-1:0] want);
        chk({nm, "_dut"}, {26'd0, bus_l.led}, {26'd0, want});
        chk({nm, "_model"}, {26'd0, exp_led_lo()}, {26'd0, want});
    endtask

    task automatic wait_shown(input int s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_shown != s && n < 200);
        if (m_shown != s) begin
            checks++;
            errors++;
            $display("FAIL wait_step: step %0d not reached within %0d cycles", s, n);
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_l.frame_strt !== 1'b1 && n < 40);
        if (bus_l.frame_strt !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_strt: no pulse within %0d cycles", n);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] left_tab  [6];
    logic [N-1:0] right_tab [6];
    logic [N-1:0] haz_tab   [3];

    initial begin
        int lat;
        left_tab  = '{6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000};
        right_tab = '{6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001, 6'b000000};
        haz_tab   = '{6'b110011, 6'b100001, 6'b000000};
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        reset  = 1'b1;
        bus_l.mode = MODE_LEFT;

        @(posedge clk);
        cmp_en = 1'b1;
        repeat (10) @(negedge clk);
        pin_led("reset_led", 6'b111111);
        chk("reset_active", {31'd0, bus_l.active}, 32'd0);
        chk("reset_fs", {31'd0, bus_l.frame_strt}, 32'd0);

        // LEFT straight out of reset
        reset = 1'b0;
        wait_fs(lat);
        chk("first_tick_latency", lat, TDIV);
        chk("left_active", {31'd0, bus_l.active}, 32'd1);
        for (int s = 0; s < 6; s++) begin
            wait_shown(ST + s);
            pin_led($sformatf("left_step%0d", ST + s), left_tab[s]);
            if (s == 0) chk("ah_left_step4", {26'd0, bus_h.led}, 32'h01);
        end
        wait_shown(FS - 1);
        pin_led("left_hold15", 6'b000000);
        wait_shown(0);
        pin_led("left_wrap", 6'b111111);
        chk("left_wrap_fs", {31'd0, bus_l.frame_strt}, 32'd1);

        // RIGHT requested mid-frame: this frame stays LEFT
        wait_shown(6);
        bus_l.mode = MODE_RIGHT;
        wait_shown(7);
        pin_led("midswitch_step7", 6'b110000);
        wait_shown(0);
        for (int s = 0; s < 6; s++) begin
            wait_shown(ST + s);
            pin_led($sformatf("right_step%0d", ST + s), right_tab[s]);
        end

        // HAZARD
        wait_shown(12);
        bus_l.mode = MODE_HAZARD;
        wait_shown(0);
        for (int s = 0; s < 3; s++) begin
            wait_shown(ST + s);
            pin_led($sformatf("hazard_step%0d", ST + s), haz_tab[s]);
        end
        wait_shown(10);
        pin_led("hazard_hold", 6'b000000);

        // OFF, then restart without waiting a full frame
        wait_shown(12);
        bus_l.mode = MODE_OFF;
        wait_shown(0);
        repeat (12) @(negedge clk);
        pin_led("off_dark", 6'b111111);
        chk("off_active", {31'd0, bus_l.active}, 32'd0);
        chk("off_step", {28'd0, bus_l.dbg_step}, 32'd0);
        bus_l.mode = MODE_LEFT;
        wait_fs(lat);
        chk("off_restart_fast", {31'd0, lat <= TDIV}, 32'd1);
        chk("off_restart_active", {31'd0, bus_l.active}, 32'd1);

        // reset in the middle of a LEFT frame
        wait_shown(7);
        reset = 1'b1;
        @(negedge clk);
        pin_led("midreset_dark", 6'b111111);
        chk("midreset_active", {31'd0, bus_l.active}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_fs(lat);
        chk("postreset_latency", lat, TDIV);

        // random mode changes and occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) bus_l.mode = mode_t'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
